// File: rtl/sdp_fifo_ctrl.sv
// sdp_fifo_ctrl: FWFT FIFO controller around an external simple dual-port RAM with a 2-entry output buffer.
// Define SDP_FIFO_AF_EN to enable the registered almost_full flag.
module sdp_fifo_ctrl #(
    parameter int DW       = 8,
    parameter int WORDS    = 256,
    parameter int AF_LEVEL = WORDS
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       in_valid,
    output logic                       in_ready,
    input  logic [DW-1:0]              in_data,
    output logic                       out_valid,
    input  logic                       out_ready,
    output logic [DW-1:0]              out_data,
    output logic [$clog2(WORDS+3)-1:0] level,
    output logic                       almost_full,
    output logic [$clog2(WORDS)-1:0]   ram_addr_a,
    output logic                       ram_wr_a,
    output logic [DW-1:0]              ram_din_a,
    output logic [$clog2(WORDS)-1:0]   ram_addr_b,
    input  logic [DW-1:0]              ram_qout_b
);
    localparam int AW = $clog2(WORDS);
    localparam int LW = $clog2(WORDS+3);

    logic [AW:0]    wptr, rptr, ram_cnt;
    logic [1:0]     ocnt, ocnt_pop;
    logic           rd_pend, push, pop, rd_go;
    logic [DW-1:0]  head, skid;
    logic [LW-1:0]  next_level;

    assign ram_cnt    = wptr - rptr;
    assign in_ready   = ram_cnt != (AW+1)'(WORDS);
    assign push       = in_valid & in_ready;
    assign out_valid  = ocnt != 2'd0;
    assign out_data   = head;
    assign pop        = out_valid & out_ready;
    assign ocnt_pop   = ocnt - {1'b0, pop};
    // Only issue a read if the returning word is guaranteed a free slot
    assign rd_go      = (ram_cnt != '0) && ({1'b0, ocnt_pop} + {2'b0, rd_pend} <= 3'd1);
    assign next_level = level + LW'(push) - LW'(pop);

    assign ram_wr_a   = push;
    assign ram_addr_a = wptr[AW-1:0];
    assign ram_din_a  = in_data;
    assign ram_addr_b = rptr[AW-1:0];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wptr    <= '0;
            rptr    <= '0;
            ocnt    <= '0;
            rd_pend <= 1'b0;
            level   <= '0;
            head    <= '0;
            skid    <= '0;
        end else begin
            wptr    <= wptr + (AW+1)'(push);
            rptr    <= rptr + (AW+1)'(rd_go);
            rd_pend <= rd_go;
            ocnt    <= ocnt_pop + {1'b0, rd_pend};
            level   <= next_level;
            if (pop && ocnt == 2'd2)
                head <= skid;
            // Returning RAM data lands in the first slot left free after this cycle's pop
            if (rd_pend) begin
                if (ocnt_pop == 2'd0)
                    head <= ram_qout_b;
                else
                    skid <= ram_qout_b;
            end
        end
    end

`ifdef SDP_FIFO_AF_EN
    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            almost_full <= 1'b0;
        else
            almost_full <= next_level >= LW'(AF_LEVEL);
    end
`else
    assign almost_full = 1'b0;
`endif

endmodule

// File: tb/tb_sdp_fifo_ctrl.sv
// tb_sdp_fifo_ctrl: scoreboard bench for sdp_fifo_ctrl (WORDS=8, AF_LEVEL=6) with a read-first RAM model.
module tb_sdp_fifo_ctrl;
    localparam int DW = 8;
    localparam int WORDS = 8;
    localparam int AF = 6;

    logic          clk = 0;
    logic          rst = 1;
    logic          in_valid = 0, out_ready = 0;
    logic          in_ready, out_valid, almost_full, ram_wr_a;
    logic [DW-1:0] in_data = 0, out_data, ram_din_a, ram_qout_b;
    logic [3:0]    level;
    logic [2:0]    ram_addr_a, ram_addr_b;
    logic [DW-1:0] mem [WORDS];

    int       tests = 0, fails = 0;
    int       exp_level = 0;
    bit       prev_stall = 0;
    logic [DW-1:0] held;
    logic [DW-1:0] q[$];

    sdp_fifo_ctrl #(.DW(DW), .WORDS(WORDS), .AF_LEVEL(AF)) dut (
        .clk(clk), .rst(rst),
        .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
        .level(level), .almost_full(almost_full),
        .ram_addr_a(ram_addr_a), .ram_wr_a(ram_wr_a), .ram_din_a(ram_din_a),
        .ram_addr_b(ram_addr_b), .ram_qout_b(ram_qout_b)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (ram_wr_a) mem[ram_addr_a] <= ram_din_a;
        ram_qout_b <= mem[ram_addr_b];
    end

    function automatic bit exp_af(input int lv);
`ifdef SDP_FIFO_AF_EN
        return lv >= AF;
`else
        return 1'b0;
`endif
    endfunction

    // One clock of stimulus; the scoreboard records writes and checks pops, level and stall stability
    task automatic step(input bit iv, input logic [DW-1:0] d, input bit ordy);
        logic [DW-1:0] e;
        in_valid = iv; in_data = d; out_ready = ordy;
        #1;
        if (prev_stall) begin
            tests++;
            if (out_valid !== 1'b1 || out_data !== held) begin
                fails++;
                $display("FAIL stall_hold: valid=%b data=%h, required valid=1 data=%h", out_valid, out_data, held);
            end
        end
        prev_stall = out_valid && !out_ready;
        held = out_data;
        if (in_valid && in_ready) begin q.push_back(in_data); exp_level++; end
        if (out_valid && out_ready) begin
            tests++;
            if (q.size() == 0) begin
                fails++;
                $display("FAIL pop_order: popped %h with nothing expected", out_data);
            end else begin
                e = q.pop_front();
                if (out_data !== e) begin
                    fails++;
                    $display("FAIL pop_order: got %h, required %h", out_data, e);
                end
            end
            exp_level--;
        end
        @(posedge clk); #1;
        tests++;
        if (level !== 4'(exp_level) || almost_full !== exp_af(exp_level)) begin
            fails++;
            $display("FAIL level: level=%0d af=%b, required level=%0d af=%b", level, almost_full, exp_level, exp_af(exp_level));
        end
        @(negedge clk);
    endtask

    task automatic drain();
        for (int i = 0; i < 60 && q.size() > 0; i++) step(0, 0, 1);
        tests++;
        if (q.size() != 0 || out_valid !== 1'b0) begin
            fails++;
            $display("FAIL drain: %0d words left, out_valid=%b, required 0 and 0", q.size(), out_valid);
        end
    endtask

    task automatic test_reset();
        rst = 1;
        repeat (2) @(negedge clk);
        tests++;
        if (out_valid !== 1'b0 || level !== 4'd0 || almost_full !== 1'b0) begin
            fails++;
            $display("FAIL reset_state: valid=%b level=%0d af=%b, required 0 0 0", out_valid, level, almost_full);
        end
        rst = 0;
        #1;
        tests++;
        if (in_ready !== 1'b1) begin
            fails++;
            $display("FAIL reset_ready: in_ready=%b, required 1", in_ready);
        end
    endtask

    task automatic test_single();
        step(1, 8'hA5, 0);
        for (int c = 1; c <= 3; c++) begin
            tests++;
            if (out_valid !== (c == 3)) begin
                fails++;
                $display("FAIL single_latency: t+%0d out_valid=%b, required %b", c, out_valid, c == 3);
            end
            if (c < 3) step(0, 0, 0);
        end
        tests++;
        if (out_data !== 8'hA5) begin
            fails++;
            $display("FAIL single_data: got %h, required a5", out_data);
        end
        step(0, 0, 1);
        tests++;
        if (out_valid !== 1'b0 || level !== 4'd0) begin
            fails++;
            $display("FAIL single_pop: valid=%b level=%0d, required 0 0", out_valid, level);
        end
    endtask

    task automatic test_full();
        for (int i = 0; i < 12; i++) step(1, 8'(i), 0);
        tests++;
        if (q.size() != WORDS + 2 || in_ready !== 1'b0 || level !== 4'(WORDS + 2)) begin
            fails++;
            $display("FAIL full: accepted=%0d in_ready=%b level=%0d, required %0d 0 %0d", q.size(), in_ready, level, WORDS + 2, WORDS + 2);
        end
        drain();
    endtask

    task automatic test_almost_full();
        for (int i = 0; i < 6; i++) step(1, 8'(40 + i), 0);
        tests++;
        if (level !== 4'd6 || almost_full !== exp_af(6)) begin
            fails++;
            $display("FAIL af_rise: level=%0d af=%b, required 6 %b", level, almost_full, exp_af(6));
        end
        step(0, 0, 1);
        tests++;
        if (level !== 4'd5 || almost_full !== 1'b0) begin
            fails++;
            $display("FAIL af_fall: level=%0d af=%b, required 5 0", level, almost_full);
        end
        drain();
    endtask

    task automatic test_streaming();
        for (int i = 0; i < 1000; i++) begin
            if (i >= 3) begin
                tests++;
                if (out_valid !== 1'b1) begin
                    fails++;
                    $display("FAIL stream_gap: cycle %0d out_valid=%b, required 1", i, out_valid);
                end
            end
            step(1, 8'(i), 1);
        end
        drain();
    endtask

    task automatic test_random();
        for (int i = 0; i < 2000; i++)
            step(1'($urandom_range(0, 1)), 8'($urandom), 1'($urandom_range(0, 1)));
        drain();
    endtask

    task automatic test_reset_midstream();
        for (int i = 0; i < 6; i++) step(1, 8'(10 + i), 0);
        step(0, 0, 1);
        tests++;
        if (level !== 4'd5) begin
            fails++;
            $display("FAIL mid_level: level=%0d, required 5", level);
        end
        #2 rst = 1;
        #1;
        tests++;
        if (out_valid !== 1'b0 || level !== 4'd0 || almost_full !== 1'b0) begin
            fails++;
            $display("FAIL mid_reset: valid=%b level=%0d af=%b, required 0 0 0", out_valid, level, almost_full);
        end
        q.delete();
        exp_level = 0;
        prev_stall = 0;
        @(negedge clk);
        rst = 0;
        step(1, 8'h3C, 0);
        drain();
    endtask

    initial begin
        test_reset();
        test_single();
        test_full();
        test_almost_full();
        test_streaming();
        test_random();
        test_reset_midstream();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule

// File: doc/sdp_fifo_ctrl.md
# sdp_fifo_ctrl

Synchronous FIFO controller that drives one external simple dual-port, read-first RAM (write port A, 1-cycle registered read port B) and turns it into a first-word-fall-through FIFO with valid/ready handshakes on both sides. It owns the pointers, the occupancy count and a 2-entry output buffer that hides the RAM read latency. It sits directly in front of the RAM macro: every RAM port is driven or consumed here, and no other logic touches the RAM.

## Interface
- DW, 8, data width; must equal the RAM data width.
- WORDS, 256, RAM depth; power of two, at least 4.
- AF_LEVEL, WORDS, almost_full threshold on `level`; used only with SDP_FIFO_AF_EN.

- clk  in  1  clock; all state updates on its rising edge.
- rst  in  1  reset; asynchronous, active-high.
- in_valid  in  1  write request.
- in_ready  out  1  space available; a write transfers when in_valid & in_ready.
- in_data  in  DW  write data.
- out_valid  out  1  head of FIFO is valid.
- out_ready  in  1  consumer accepts; a pop occurs when out_valid & out_ready.
- out_data  out  DW  head data; held stable while out_valid & !out_ready.
- level  out  $clog2(WORDS+3)  total entries held (RAM + in-flight read + output buffer).
- almost_full  out  1  level >= AF_LEVEL (see Configuration).
- ram_addr_a  out  $clog2(WORDS)  RAM write address.
- ram_wr_a  out  1  RAM write enable.
- ram_din_a  out  DW  RAM write data.
- ram_addr_b  out  $clog2(WORDS)  RAM read address.
- ram_qout_b  in  DW  RAM read data, valid the cycle after ram_addr_b is presented.

## Operation
- wptr, rptr: $clog2(WORDS)+1 bits (wrap bit); ram_cnt = wptr - rptr, range 0..WORDS.
- Write: ram_wr_a = in_valid & in_ready (combinational); ram_addr_a = wptr[low bits]; ram_din_a = in_data; wptr += 1 on a transfer.
- in_ready = (ram_cnt != WORDS). Capacity is WORDS + 2 entries overall.
- Read issue: rd_go = (ram_cnt != 0) & (ocnt + rd_pend - pop <= 1); ram_addr_b = rptr[low bits]; rptr += 1 and rd_pend <= 1 on rd_go, else rd_pend <= 0.
- Output buffer: two registers (head, skid), occupancy ocnt 0..2. When rd_pend, ram_qout_b is written into the first free slot after the pop; on a pop with ocnt = 2, skid shifts to head in the same edge.
- out_valid = (ocnt != 0); out_data = head register.
- Simultaneous write and rd_go in one cycle: both pointers advance; ram_cnt unchanged.
- Read-first collision cannot occur: reads target only occupied slots, writes only free slots.
- Pointer wrap: the low bits roll over from WORDS-1 to 0, and the wrap bit toggles. Full/empty is decided only from ram_cnt.
- Reset, asynchronous and at any point: wptr, rptr, ocnt, rd_pend and level go to 0, out_valid to 0 and almost_full to 0. An in-flight read and buffered data are discarded. RAM contents are not cleared. in_ready = 1 as soon as rst is deasserted.

## Timing
- Write-to-read latency, empty FIFO: a write in cycle t becomes visible in RAM at t+1, where rd_go fires. ram_qout_b is valid at t+2, and out_valid is high in t+3.
- Sustained throughput: 1 word/cycle in each direction while out_ready stays high.
- in_ready falls in the cycle after the write that makes ram_cnt = WORDS.
- level updates on the edge of every transfer and counts +1 per write and -1 per pop. It is registered.

## Configuration
- SDP_FIFO_AF_EN defined: almost_full is a register updated every cycle from the next-state level (next_level >= AF_LEVEL). It reflects the level on the same edge.
- SDP_FIFO_AF_EN undefined: almost_full is tied to 0, and AF_LEVEL is ignored.

## Test plan
- Reset, then a single write of 0xA5 at cycle t: out_valid rises at t+3 with out_data = 0xA5, and level = 1 from t+1. A pop returns level to 0 and out_valid to 0.
- WORDS=4, out_ready=0, write continuously: 6 words are accepted (4 in RAM, 2 buffered), then in_ready = 0 and level = 6. Drain returns values 0..5 in order.
- Streaming with in_valid=out_ready=1 for 1000 cycles on an incrementing pattern: after the 3-cycle fill, one word is output per cycle, with no gaps and no reordering across pointer wrap.
- out_ready random 50%, in_valid random 50%: the output sequence equals the input sequence, out_data is stable while stalled, and level equals writes minus pops every cycle.
- Assert rst mid-stream with level = 5 and a read in flight: the next edge shows out_valid = 0 and level = 0. The following write of 0x3C is the first word output.
- With SDP_FIFO_AF_EN, WORDS=8, AF_LEVEL=6: almost_full goes to 1 on the edge where level becomes 6. It returns to 0 on the pop that takes level to 5. Without the macro, almost_full stays 0 throughout.
